// File: rtl/fft_in_framer.sv
// fft_in_framer: frames a gappy sample stream into FFT-length symbols with sop/eop markers.
// Optional error checking (frm_err pulse, saturating err_cnt) is built only when
// FFT_FRAMER_ERR_CHK_EN is defined; otherwise both outputs are tied to zero.
module fft_in_framer #(
    parameter int DATA_NBIT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           fft_num,
    input  logic                 cp_type,
    input  logic                 fft_type,
    input  logic [DATA_NBIT-1:0] source_i,
    input  logic [DATA_NBIT-1:0] source_q,
    input  logic                 source_h,
    input  logic                 source_s,
    input  logic                 source_v,
    output logic [DATA_NBIT-1:0] fft_din_i,
    output logic [DATA_NBIT-1:0] fft_din_q,
    output logic                 fft_din_v,
    output logic                 fft_din_sop,
    output logic                 fft_din_eop,
    output logic [11:0]          fft_len_o,
    output logic                 fft_type_o,
    output logic [2:0]           sym_idx,
    output logic                 frm_err,
    output logic [7:0]           err_cnt
);

    typedef enum logic [1:0] {IDLE, ARMED, CAPT} state_t;

    state_t               state_q, state_d;
    logic [11:0]          cnt_q, cnt_d, cnt_inc;
    logic [11:0]          len_q, len_d;
    logic                 type_q, type_d;
    logic [2:0]           sym_q, sym_d, sym_max;
    logic [DATA_NBIT-1:0] di_q, di_d, dq_q, dq_d;
    logic                 v_q, v_d, sop_q, sop_d, eop_q, eop_d;

    function automatic logic [11:0] len_of(input logic [1:0] n);
        return n == 2'd0 ? 12'd2048 : n == 2'd1 ? 12'd1536 : n == 2'd2 ? 12'd1024 : 12'd512;
    endfunction

    // Next-state: a header always re-arms (and may carry the first sample); otherwise run the frame FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        type_d  = type_q;
        sym_d   = sym_q;
        v_d     = 1'b0;
        sop_d   = 1'b0;
        eop_d   = 1'b0;
        cnt_inc = cnt_q + 12'd1;
        sym_max = cp_type ? 3'd5 : 3'd6;
        if (source_h) begin
            len_d   = len_of(fft_num);
            type_d  = fft_type;
            sym_d   = (source_s || sym_q >= sym_max) ? 3'd0 : sym_q + 3'd1;
            state_d = source_v ? CAPT : ARMED;
            cnt_d   = source_v ? 12'd1 : 12'd0;
            v_d     = source_v;
            sop_d   = source_v;
        end else begin
            case (state_q)
                ARMED: if (source_v) begin
                    v_d     = 1'b1;
                    sop_d   = 1'b1;
                    cnt_d   = 12'd1;
                    state_d = CAPT;
                end
                CAPT: if (source_v) begin
                    v_d     = 1'b1;
                    eop_d   = cnt_inc == len_q;
                    cnt_d   = eop_d ? 12'd0 : cnt_inc;
                    state_d = eop_d ? IDLE : CAPT;
                end
                default: ;
            endcase
        end
        di_d = v_d ? source_i : '0;
        dq_d = v_d ? source_q : '0;
    end

    // State, latched configuration and the single output register stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= 12'd2048;
            type_q  <= 1'b0;
            sym_q   <= '0;
            di_q    <= '0;
            dq_q    <= '0;
            v_q     <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            type_q  <= type_d;
            sym_q   <= sym_d;
            di_q    <= di_d;
            dq_q    <= dq_d;
            v_q     <= v_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
        end
    end

    assign fft_din_i   = di_q;
    assign fft_din_q   = dq_q;
    assign fft_din_v   = v_q;
    assign fft_din_sop = sop_q;
    assign fft_din_eop = eop_q;
    assign fft_len_o   = len_q;
    assign fft_type_o  = type_q;
    assign sym_idx     = sym_q;

`ifdef FFT_FRAMER_ERR_CHK_EN
    logic       err_ev, err_q;
    logic [7:0] err_cnt_q;

    // A header cutting a capture short, or a valid arriving with no frame open, is an error.
    assign err_ev = source_h ? (state_q == CAPT) : (source_v && state_q == IDLE);

    // One-cycle error pulse and saturating error counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            err_q     <= err_ev;
            err_cnt_q <= (err_ev && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
        end
    end

    assign frm_err = err_q;
    assign err_cnt = err_cnt_q;
`else
    assign frm_err = 1'b0;
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_fft_in_framer.sv
// tb_fft_in_framer: directed stimulus with an expected-sample queue checked by a decoupled monitor.
module tb_fft_in_framer;

    localparam int W = 16;
`ifdef FFT_FRAMER_ERR_CHK_EN
    localparam int EN = 1;
`else
    localparam int EN = 0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [1:0]   fft_num = '0;
    logic         cp_type = 1'b0, fft_type = 1'b0;
    logic [W-1:0] source_i = '0, source_q = '0;
    logic         source_h = 1'b0, source_s = 1'b0, source_v = 1'b0;
    logic [W-1:0] fft_din_i, fft_din_q;
    logic         fft_din_v, fft_din_sop, fft_din_eop;
    logic [11:0]  fft_len_o;
    logic         fft_type_o;
    logic [2:0]   sym_idx;
    logic         frm_err;
    logic [7:0]   err_cnt;

    fft_in_framer #(.DATA_NBIT(W)) dut (
        .clk(clk), .reset(reset), .fft_num(fft_num), .cp_type(cp_type), .fft_type(fft_type),
        .source_i(source_i), .source_q(source_q), .source_h(source_h), .source_s(source_s),
        .source_v(source_v), .fft_din_i(fft_din_i), .fft_din_q(fft_din_q), .fft_din_v(fft_din_v),
        .fft_din_sop(fft_din_sop), .fft_din_eop(fft_din_eop), .fft_len_o(fft_len_o),
        .fft_type_o(fft_type_o), .sym_idx(sym_idx), .frm_err(frm_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] i;
        logic [W-1:0] q;
        logic         sop;
        logic         eop;
        int           cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_cmp = 0, n_bad = 0, cyc = 0, err_hi = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frm_err) err_hi++;
        if (fft_din_v) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_out: got i=%0h q=%0h with no sample expected", fft_din_i, fft_din_q);
            end else begin
                e = exp_q.pop_front();
                chk("sample{cyc,i,q,sop,eop}", {16'(cyc), fft_din_i, fft_din_q, fft_din_sop, fft_din_eop},
                    {16'(e.cyc), e.i, e.q, e.sop, e.eop});
            end
        end else begin
            chk("idle_zero{i,q,sop,eop}", {fft_din_i, fft_din_q, fft_din_sop, fft_din_eop}, 64'd0);
        end
    end

    task automatic drive(input logic h, input logic s, input logic v, input logic [W-1:0] d,
                         input logic ev, input logic sop, input logic eop);
        source_h = h;
        source_s = s;
        source_v = v;
        source_i = d;
        source_q = ~d;
        if (ev) exp_q.push_back('{i: d, q: ~d, sop: sop, eop: eop, cyc: cyc + 1});
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        for (int t = 0; t < 8 && exp_q.size() != 0; t++) begin
            @(negedge clk);
            #1;
        end
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_v", fft_din_v, 0);
        chk("rst_len", fft_len_o, 2048);
        chk("rst_type", fft_type_o, 0);
        chk("rst_sym", sym_idx, 0);
        chk("rst_err", {frm_err, err_cnt}, 0);
        reset = 1'b1;

        for (int k = 0; k < 3; k++) drive(0, 0, 1, 16'(16'h0100 + k), 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("orphan_cnt", err_cnt, EN ? 3 : 0);
        chk("orphan_pulses", err_hi, EN ? 3 : 0);

        fft_num = 2'd0; cp_type = 1'b0; fft_type = 1'b1;
        drive(1, 1, 0, 0, 0, 0, 0);
        for (int n = 0; n < 2048; n++) begin
            fft_num  = 2'(n);
            fft_type = 1'(n);
            drive(0, 0, 1, 16'(n), 1, n == 0, n == 2047);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        drain("f2048_drain");
        chk("f2048_len", fft_len_o, 2048);
        chk("f2048_type", fft_type_o, 1);

        fft_num = 2'd0; cp_type = 1'b0;
        for (int k = 0; k < 7; k++) begin
            drive(1, k == 0, 0, 0, 0, 0, 0);
            chk("sym_normal", sym_idx, 64'(k));
        end
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("sym_normal_wrap", sym_idx, 0);
        cp_type = 1'b1;
        for (int k = 0; k < 6; k++) begin
            drive(1, k == 0, 0, 0, 0, 0, 0);
            chk("sym_ext", sym_idx, 64'(k));
        end
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("sym_ext_wrap", sym_idx, 0);

        cp_type = 1'b0; fft_num = 2'd3;
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("f512_len", fft_len_o, 512);
        for (int n = 0; n < 1024; n++) begin
            fft_num = 2'd0;
            drive(0, 0, n % 2 == 0, 16'(16'h4000 + n), n % 2 == 0, n == 0, n == 1022);
        end
        drain("f512_gap_drain");

        fft_num = 2'd2;
        drive(1, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 300; n++) drive(0, 0, 1, 16'(16'h8000 + n), 1, n == 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 1024; n++) drive(0, 0, 1, 16'(16'hA000 + n), 1, n == 0, n == 1023);
        drive(0, 0, 0, 0, 0, 0, 0);
        drain("short_drain");
        chk("short_err_cnt", err_cnt, EN ? 4 : 0);
        chk("short_pulses", err_hi, EN ? 4 : 0);
        chk("short_len", fft_len_o, 1024);

        fft_num = 2'd3;
        drive(1, 0, 1, 16'hC000, 1, 1, 0);
        for (int n = 1; n < 512; n++) drive(0, 0, 1, 16'(16'hC000 + n), 1, 0, n == 511);
        drive(0, 0, 0, 0, 0, 0, 0);
        drain("hv_coincide_drain");
        chk("hv_err_cnt", err_cnt, EN ? 4 : 0);

        fft_num = 2'd0; fft_type = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 999; n++) drive(0, 0, 1, 16'(16'h2000 + n), 1, n == 0, 0);
        drive(0, 0, 1, 16'h2777, 0, 0, 0);
        chk("pre_rst_v", fft_din_v, 1);
        reset = 1'b0;
        #1;
        chk("rst_mid_out", {fft_din_v, fft_din_i, fft_din_q, fft_din_sop, fft_din_eop}, 0);
        chk("rst_mid_len", fft_len_o, 2048);
        chk("rst_mid_type", fft_type_o, 0);
        chk("rst_mid_sym_err", {sym_idx, frm_err, err_cnt}, 0);
        drive(0, 0, 1, 16'h3000, 0, 0, 0);
        drive(0, 0, 1, 16'h3001, 0, 0, 0);
        reset = 1'b1;
        for (int k = 0; k < 5; k++) drive(0, 0, 1, 16'(16'h3100 + k), 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("post_rst_orphans", err_cnt, EN ? 5 : 0);
        fft_num = 2'd3;
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("post_rst_sym", sym_idx, 1);
        for (int n = 0; n < 512; n++) drive(0, 0, 1, 16'(16'h5000 + n), 1, n == 0, n == 511);
        drive(0, 0, 0, 0, 0, 0, 0);
        drain("post_rst_drain");
        chk("total_pulses", err_hi, EN ? 9 : 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
